// File: rtl/bsg_upstream_link_tx.sv
// Credit-flow-controlled upstream link transmitter: buffers core words in a
// hold/shift pair and serialises each one over CH_NUM channels in BEATS beats.
module bsg_upstream_link_tx #(
    parameter int DATA_W  = 64,
    parameter int CH_NUM  = 2,
    parameter int CH_W    = 8,
    parameter int CREDITS = 64,
    parameter int BEATS   = DATA_W / (CH_NUM * CH_W),
    parameter int CNT_W   = $clog2(CREDITS) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      core_data_in,
    input  logic                   core_valid_in,
    output logic                   core_ready_out,
    input  logic                   io_token,
    output logic                   io_valid_out,
    output logic [CH_NUM*CH_W-1:0] io_data_out,
    output logic [CNT_W-1:0]       credit_avail,
    output logic                   credit_err
);

    localparam int IO_W   = CH_NUM * CH_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CREDITS_C = CNT_W'(CREDITS);

    // Channel c of beat b carries the word slice [(c*BEATS+b)*CH_W +: CH_W].
    function automatic logic [IO_W-1:0] beat_slice(
        input logic [DATA_W-1:0] w,
        input logic [BEAT_W-1:0] b
    );
        logic [IO_W-1:0] s;
        s = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            s[c*CH_W +: CH_W] = w[(c*BEATS + 32'(b))*CH_W +: CH_W];
        end
        return s;
    endfunction

    logic [0:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              io_valid_q, io_valid_d;
    logic [IO_W-1:0]   io_data_q, io_data_d;
    logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0]  finish_cnt_q, finish_cnt_d;
    logic              credit_err_q, credit_err_d;

    logic [CNT_W-1:0]  outstanding;
    logic              credit_ok;
    logic              slot_free;
    logic              launch;
    logic              accept;
    logic              token_ok;

    always_comb begin
        // Outstanding count relies on modulo-2^CNT_W subtraction across wrap.
        outstanding    = sent_cnt_q - finish_cnt_q;
        credit_ok      = outstanding < CREDITS_C;
        slot_free      = (state_q == ST_IDLE) || (beat_q == LAST_BEAT);
        launch         = hold_v_q && credit_ok && slot_free;
        core_ready_out = !hold_v_q || launch;
        accept         = core_valid_in && core_ready_out;
        token_ok       = io_token && (sent_cnt_q != finish_cnt_q);
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        hold_v_d     = hold_v_q;
        hold_data_d  = hold_data_q;
        shift_d      = shift_q;
        io_valid_d   = io_valid_q;
        io_data_d    = io_data_q;
        sent_cnt_d   = sent_cnt_q;
        finish_cnt_d = finish_cnt_q;
        credit_err_d = credit_err_q;

        if (accept) begin
            hold_data_d = core_data_in;
            hold_v_d    = 1'b1;
        end else if (launch) begin
            hold_v_d    = 1'b0;
        end

        // Beat 0 comes straight from the hold register so it appears one
        // cycle after launch; later beats come from the shift register.
        if (launch) begin
            shift_d    = hold_data_q;
            sent_cnt_d = sent_cnt_q + CNT_W'(1);
            state_d    = ST_SEND;
            beat_d     = '0;
            io_valid_d = 1'b1;
            io_data_d  = beat_slice(hold_data_q, '0);
        end else if (state_q == ST_SEND) begin
            if (beat_q != LAST_BEAT) begin
                beat_d     = beat_q + BEAT_W'(1);
                io_valid_d = 1'b1;
                io_data_d  = beat_slice(shift_q, beat_q + BEAT_W'(1));
            end else begin
                state_d    = ST_IDLE;
                beat_d     = '0;
                io_valid_d = 1'b0;
                io_data_d  = '0;
            end
        end

        if (token_ok) begin
            finish_cnt_d = finish_cnt_q + CNT_W'(1);
        end
        if (io_token && !token_ok) begin
            credit_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            hold_v_q     <= 1'b0;
            hold_data_q  <= '0;
            shift_q      <= '0;
            io_valid_q   <= 1'b0;
            io_data_q    <= '0;
            sent_cnt_q   <= '0;
            finish_cnt_q <= '0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            hold_v_q     <= hold_v_d;
            hold_data_q  <= hold_data_d;
            shift_q      <= shift_d;
            io_valid_q   <= io_valid_d;
            io_data_q    <= io_data_d;
            sent_cnt_q   <= sent_cnt_d;
            finish_cnt_q <= finish_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign io_valid_out = io_valid_q;
    assign io_data_out  = io_data_q;
    assign credit_avail = CREDITS_C - outstanding;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_bsg_upstream_link_tx.sv
// Directed bench for bsg_upstream_link_tx at default parameters: vector table
// for beat mapping plus hand-written sequences for credit, reset and streaming.
module tb_bsg_upstream_link_tx;

    localparam int BOUND = 300;

    logic        clk;
    logic        rst;
    logic [63:0] core_data_in;
    logic        core_valid_in;
    logic        core_ready_out;
    logic        io_token;
    logic        io_valid_out;
    logic [15:0] io_data_out;
    logic [6:0]  credit_avail;
    logic        credit_err;

    bsg_upstream_link_tx #(
        .DATA_W(64),
        .CH_NUM(2),
        .CH_W(8),
        .CREDITS(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core_data_in(core_data_in),
        .core_valid_in(core_valid_in),
        .core_ready_out(core_ready_out),
        .io_token(io_token),
        .io_valid_out(io_valid_out),
        .io_data_out(io_data_out),
        .credit_avail(credit_avail),
        .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [15:0] beat [4];
    } vec_t;

    vec_t        vecs [4];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Streams n random words; the monitor rebuilds each word from its beats
    // (ch0 = low half, ch1 = high half) and optionally returns one token per word.
    task automatic run_stream(input int n, input bit tokens, output int stalls, output int max_run);
        bit drv_to;
        int got;
        stalls  = 0;
        max_run = 0;
        drv_to  = 1'b0;
        got     = 0;
        fork
            begin
                for (int i = 0; i < n && !drv_to; i++) begin
                    logic [63:0] w;
                    int guard;
                    w = {32'($urandom()), 32'($urandom())};
                    core_data_in  = w;
                    core_valid_in = 1'b1;
                    guard = 0;
                    while (!core_ready_out && guard < BOUND) begin
                        stalls++;
                        guard++;
                        tick();
                    end
                    if (guard >= BOUND) drv_to = 1'b1;
                    else begin
                        exp_q.push_back(w);
                        tick();
                    end
                end
                core_valid_in = 1'b0;
                core_data_in  = '0;
            end
            begin
                int beat;
                int run;
                int idle;
                logic [63:0] acc;
                beat = 0;
                run  = 0;
                idle = 0;
                acc  = '0;
                while (got < n && idle < BOUND) begin
                    tick();
                    io_token = 1'b0;
                    if (io_valid_out) begin
                        idle = 0;
                        run++;
                        if (run > max_run) max_run = run;
                        acc[beat*8 +: 8]      = io_data_out[7:0];
                        acc[32 + beat*8 +: 8] = io_data_out[15:8];
                        if (beat == 3) begin
                            logic [63:0] e;
                            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                            check("stream_word", acc, e);
                            got++;
                            beat = 0;
                            if (tokens) io_token = 1'b1;
                        end else begin
                            beat++;
                        end
                    end else begin
                        run = 0;
                        idle++;
                    end
                end
            end
        join
        check("stream_words_seen", 64'(got), 64'(n));
        check("stream_driver_bound", {63'd0, drv_to}, 64'd0);
        if (io_token) begin
            tick();
            io_token = 1'b0;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int max_run;

        vecs[0].word = 64'h8877665544332211;
        vecs[0].beat = '{16'h5511, 16'h6622, 16'h7733, 16'h8844};
        vecs[1].word = 64'h0123456789ABCDEF;
        vecs[1].beat = '{16'h67EF, 16'h45CD, 16'h23AB, 16'h0189};
        vecs[2].word = 64'hFFFFFFFF00000000;
        vecs[2].beat = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        vecs[3].word = 64'hDEADBEEFCAFEF00D;
        vecs[3].beat = '{16'hEF0D, 16'hBEF0, 16'hADFE, 16'hDECA};

        rst           = 1'b1;
        core_data_in  = '0;
        core_valid_in = 1'b0;
        io_token      = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", io_valid_out, 0);
        check("rst_data", io_data_out, 0);
        check("rst_credit", credit_avail, 64);
        check("rst_err", credit_err, 0);
        check("rst_ready", core_ready_out, 1);
        rst = 1'b0;
        tick();

        // Single words: latency, beat mapping, credit consumption
        for (int i = 0; i < 4; i++) begin
            core_data_in  = vecs[i].word;
            core_valid_in = 1'b1;
            check("idle_ready", core_ready_out, 1);
            tick();
            core_valid_in = 1'b0;
            core_data_in  = 64'hA5A5A5A5A5A5A5A5;
            check("pre_launch_valid", io_valid_out, 0);
            tick();
            for (int b = 0; b < 4; b++) begin
                check("beat_valid", io_valid_out, 1);
                check("beat_data", io_data_out, vecs[i].beat[b]);
                if (b == 0) check("credit_dec", credit_avail, 64'(63 - i));
                tick();
            end
            check("post_word_valid", io_valid_out, 0);
        end

        // Back-to-back words: 12 gapless beats, 3 stall cycles on the third word
        do_reset();
        run_stream(3, 1'b0, stalls, max_run);
        check("b2b_run", 64'(max_run), 12);
        check("b2b_stalls", 64'(stalls), 3);

        // Credit exhaustion: 65th word held until a token arrives
        do_reset();
        run_stream(64, 1'b0, stalls, max_run);
        check("exhaust_credit", credit_avail, 0);
        core_data_in  = vecs[1].word;
        core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        core_data_in  = '0;
        check("held_valid", io_valid_out, 0);
        check("held_ready", core_ready_out, 0);
        repeat (3) tick();
        check("held_valid_later", io_valid_out, 0);
        check("held_credit", credit_avail, 0);
        io_token = 1'b1;
        tick();
        io_token = 1'b0;
        check("token_no_same_cycle_launch", io_valid_out, 0);
        check("token_credit", credit_avail, 1);
        tick();
        check("resume_valid", io_valid_out, 1);
        check("resume_credit", credit_avail, 0);
        for (int b = 0; b < 4; b++) begin
            check("resume_data", io_data_out, vecs[1].beat[b]);
            tick();
        end
        check("resume_done", io_valid_out, 0);

        // Token coincident with launch keeps credit_avail unchanged
        io_token = 1'b1;
        repeat (10) tick();
        io_token = 1'b0;
        check("ten_tokens_credit", credit_avail, 10);
        core_data_in  = vecs[2].word;
        core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        check("accept_credit", credit_avail, 10);
        io_token = 1'b1;
        tick();
        io_token = 1'b0;
        check("coincident_credit", credit_avail, 10);
        check("coincident_valid", io_valid_out, 1);
        check("coincident_data", io_data_out, vecs[2].beat[0]);
        repeat (4) tick();

        // Token with nothing outstanding
        do_reset();
        io_token = 1'b1;
        tick();
        io_token = 1'b0;
        check("err_set", credit_err, 1);
        check("err_finish_unchanged", credit_avail, 64);
        repeat (3) tick();
        check("err_sticky", credit_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_cleared", credit_err, 0);

        // Reset during beat 2 aborts the word
        tick();
        core_data_in  = vecs[3].word;
        core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        repeat (3) tick();
        check("abort_beat2", io_data_out, vecs[3].beat[2]);
        rst = 1'b1;
        tick();
        check("abort_valid", io_valid_out, 0);
        check("abort_credit", credit_avail, 64);
        check("abort_ready", core_ready_out, 1);
        rst = 1'b0;
        tick();
        check("abort_no_more_beats", io_valid_out, 0);
        tick();
        check("abort_still_idle", io_valid_out, 0);

        // 200 words with tokens returned: counters wrap past 2^7
        run_stream(200, 1'b1, stalls, max_run);
        repeat (2) tick();
        check("wrap_queue_empty", 64'(exp_q.size()), 0);
        check("wrap_credit", credit_avail, 64);
        check("wrap_err", credit_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
